// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, state encoding and write command layout for the register file write arbiter.
package regfile_pkg;

   localparam int unsigned ADDR_W   = 6;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR,
      RUN
   } arb_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_cmd_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes plus register file port A / write port signals of the write arbiter.
interface regfile_write_arbiter_if;

   logic                          Req0Valid;
   logic                          Req0Ready;
   logic [regfile_pkg::ADDR_W-1:0] Req0Address;
   logic [regfile_pkg::DATA_W-1:0] Req0Data;
   logic                          Req1Valid;
   logic                          Req1Ready;
   logic [regfile_pkg::ADDR_W-1:0] Req1Address;
   logic [regfile_pkg::DATA_W-1:0] Req1Data;
   logic [regfile_pkg::ADDR_W-1:0] ReadAddressA;
   logic [regfile_pkg::ADDR_W-1:0] RfAddressA;
   logic [regfile_pkg::DATA_W-1:0] RfWriteData;
   logic                          RfWriteEnable;
   logic                          PortABusy;
   logic                          Busy;

   // Arbiter side.
   modport slave (
      input  Req0Valid, Req0Address, Req0Data,
      input  Req1Valid, Req1Address, Req1Data,
      input  ReadAddressA,
      output Req0Ready, Req1Ready,
      output RfAddressA, RfWriteData, RfWriteEnable, PortABusy, Busy
   );

   // Requester / consumer side.
   modport master (
      output Req0Valid, Req0Address, Req0Data,
      output Req1Valid, Req1Address, Req1Data,
      output ReadAddressA,
      input  Req0Ready, Req1Ready,
      input  RfAddressA, RfWriteData, RfWriteEnable, PortABusy, Busy
   );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; LastGrant resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
   input  logic Clock,
   input  logic nReset,
   input  logic Enable,
   input  logic Valid0,
   input  logic Valid1,
   output logic Grant0,
   output logic Grant1
);

   logic LastGrant;

   always_comb begin
      Grant0 = 1'b0;
      Grant1 = 1'b0;
      if (Enable) begin
         if (Valid0 && Valid1) begin
            Grant0 = LastGrant;
            Grant1 = !LastGrant;
         end else begin
            Grant0 = Valid0;
            Grant1 = Valid1;
         end
      end
   end

   // A grant is always a transfer since grants only go to valid requesters.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         LastGrant <= 1'b1;
      end else if (Grant0 || Grant1) begin
         LastGrant <= Grant1;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port (through AddressA) between ALU writeback and load/debug.
// Macro REGFILE_CLEAR_EN adds a post-reset zero sweep of all registers.
module regfile_write_arbiter
   import regfile_pkg::*;
(
   input logic                    Clock,
   input logic                    nReset,
   regfile_write_arbiter_if.slave Bus
);

   arb_state_t State;
   wr_cmd_t    WrCmd;
   logic       WrEnable;
   logic       Grant0;
   logic       Grant1;
   logic       RunEnable;

`ifdef REGFILE_CLEAR_EN
   logic [ADDR_W-1:0] ClearCount;
   logic              BusyQ;
   assign Bus.Busy = BusyQ;
`else
   assign Bus.Busy = 1'b0;
`endif

   assign RunEnable = (State == RUN);

   rr_arbiter2 uArb (
      .Clock  (Clock),
      .nReset (nReset),
      .Enable (RunEnable),
      .Valid0 (Bus.Req0Valid),
      .Valid1 (Bus.Req1Valid),
      .Grant0 (Grant0),
      .Grant1 (Grant1)
   );

   assign Bus.Req0Ready     = Grant0;
   assign Bus.Req1Ready     = Grant1;
   // Port A is lent to the write only while a write is on the bus.
   assign Bus.RfAddressA    = WrEnable ? WrCmd.addr : Bus.ReadAddressA;
   assign Bus.RfWriteData   = WrCmd.data;
   assign Bus.RfWriteEnable = WrEnable;
   assign Bus.PortABusy     = WrEnable;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
`ifdef REGFILE_CLEAR_EN
         State      <= CLEAR;
         ClearCount <= '0;
         BusyQ      <= 1'b1;
`else
         State      <= RUN;
`endif
         WrEnable   <= 1'b0;
         WrCmd      <= '0;
      end else begin
         case (State)
`ifdef REGFILE_CLEAR_EN
            CLEAR: begin
               WrEnable   <= 1'b1;
               WrCmd      <= '{addr: ClearCount, data: '0};
               ClearCount <= ClearCount + 1'b1;
               if (ClearCount == ADDR_W'(NUM_REGS - 1)) begin
                  State <= RUN;
                  BusyQ <= 1'b0;
               end
            end
`endif
            default: begin
               WrEnable <= Grant0 || Grant1;
               if (Grant1) begin
                  WrCmd <= '{addr: Bus.Req1Address, data: Bus.Req1Data};
               end else if (Grant0) begin
                  WrCmd <= '{addr: Bus.Req0Address, data: Bus.Req0Data};
               end
            end
         endcase
      end
   end

endmodule
